// File: rtl/trace_event_scheduler_pkg.sv
// Shared trace definitions: FIFO command codes, default field widths and the
// scheduler FSM encoding.
package trace_event_scheduler_pkg;

    localparam int unsigned TES_NUM_RULES = 8;
    localparam int unsigned TES_SHORT_W   = 8;
    localparam int unsigned TES_FULL_W    = 16;
    localparam int unsigned TES_RULE_W    = 8;

    typedef logic [1:0] fe_fifo_cmd_t;

    localparam fe_fifo_cmd_t FE_FIFO_CMD_NONE  = 2'b00;
    localparam fe_fifo_cmd_t FE_FIFO_CMD_TIME  = 2'b01;
    localparam fe_fifo_cmd_t FE_FIFO_CMD_MATCH = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_EMIT_TIME  = 2'b01,
        ST_EMIT_MATCH = 2'b10,
        ST_BLOCKED    = 2'b11
    } tes_state_e;

endpackage

// File: rtl/trace_event_scheduler_if.sv
// Sniff FIFO write port: the scheduler drives the record, the FIFO reports full.
interface trace_event_scheduler_if #(
    parameter int unsigned pFULL_W = 16
);
    logic               fifo_wr;
    logic [1:0]         fifo_cmd;
    logic [7:0]         fifo_rule;
    logic [pFULL_W-1:0] fifo_time;
    logic               fifo_full;

    modport master (
        output fifo_wr,
        output fifo_cmd,
        output fifo_rule,
        output fifo_time,
        input  fifo_full
    );

    modport slave (
        input  fifo_wr,
        input  fifo_cmd,
        input  fifo_rule,
        input  fifo_time,
        output fifo_full
    );
endinterface

// File: rtl/trace_event_scheduler_prio_pick.sv
// Lowest-set-bit picker: returns the index of the lowest request bit and a
// one-hot mask that clears exactly that bit.
module trace_prio_pick #(
    parameter int unsigned pNUM_RULES = 8
) (
    input  logic [pNUM_RULES-1:0] req,
    output logic [7:0]            idx,
    output logic [pNUM_RULES-1:0] clr_mask
);

    // Two's-complement trick isolates the lowest set bit; the index is the
    // OR of the positions of a one-hot vector, so no priority chain is needed.
    always_comb begin
        clr_mask = req & (~req + {{(pNUM_RULES-1){1'b0}}, 1'b1});
        idx      = 8'd0;
        for (int i = 0; i < int'(pNUM_RULES); i++) begin
            idx = idx | (clr_mask[i] ? 8'(i) : 8'd0);
        end
    end

endmodule

// File: rtl/trace_event_scheduler.sv
// Serialises pattern-matcher hits onto the sniff FIFO write port as MATCH
// records, prefixed by a TIME record when the gap overflows the short field.
module trace_event_scheduler
    import trace_event_scheduler_pkg::*;
#(
    parameter int unsigned pNUM_RULES = TES_NUM_RULES,
    parameter int unsigned pSHORT_W   = TES_SHORT_W,
    parameter int unsigned pFULL_W    = TES_FULL_W
) (
    input  logic                    trace_clk,
    input  logic                    resetn,
    input  logic                    arm,
    input  logic [pNUM_RULES-1:0]   match_hit,
    input  logic [pNUM_RULES-1:0]   rule_enable,
    input  logic [pNUM_RULES-1:0]   trig_enable,
    trace_event_scheduler_if.master fifo,
    output logic                    trig_out,
    output logic                    overflow_blocked,
    output logic                    busy
);

    localparam logic [pFULL_W-1:0] DELTA_MAX = {pFULL_W{1'b1}};
    localparam logic [pFULL_W-1:0] LOW_MASK  = {{(pFULL_W-pSHORT_W){1'b0}}, {pSHORT_W{1'b1}}};
    localparam logic [pFULL_W-1:0] DELTA_ONE = {{(pFULL_W-1){1'b0}}, 1'b1};

    tes_state_e              state_r;
    tes_state_e              state_next_s;
    logic                    arm_q_r;
    logic [pFULL_W-1:0]      delta_r;
    logic [pFULL_W-1:0]      sdelta_r;
    logic [pNUM_RULES-1:0]   stage_r;
    logic [pNUM_RULES-1:0]   stage_next_s;
    logic                    first_r;
    logic                    first_next_s;
    logic                    overflow_r;
    logic                    busy_r;

    logic                    arm_rise_s;
    logic                    live_s;
    logic [pNUM_RULES-1:0]   hits_s;
    logic                    hit_any_s;
    logic                    emit_s;
    logic                    block_s;
    logic                    capture_s;
    logic                    write_s;
    logic [7:0]              pick_idx_s;
    logic [pNUM_RULES-1:0]   pick_clr_s;
    logic [pNUM_RULES-1:0]   stage_after_s;

    logic                    wr_s;
    fe_fifo_cmd_t            cmd_s;
    logic [7:0]              rule_s;
    logic [pFULL_W-1:0]      time_s;
    logic                    trig_s;

    // An arm rising edge is a restart cycle: nothing is captured or written on it.
    assign arm_rise_s    = arm & ~arm_q_r;
    assign live_s        = arm & ~arm_rise_s;
    assign hits_s        = match_hit & rule_enable;
    assign hit_any_s     = |hits_s;
    assign emit_s        = (state_r == ST_EMIT_TIME) || (state_r == ST_EMIT_MATCH);
    assign write_s       = live_s & emit_s & ~fifo.fifo_full;
    assign capture_s     = live_s & hit_any_s & (state_r == ST_IDLE) & ~(|stage_r) & ~fifo.fifo_full;
    assign block_s       = live_s & ((emit_s & fifo.fifo_full) |
                           (hit_any_s & (state_r != ST_BLOCKED) & ((|stage_r) | fifo.fifo_full)));
    assign stage_after_s = stage_r & ~pick_clr_s;

    trace_prio_pick #(
        .pNUM_RULES (pNUM_RULES)
    ) u_prio_pick (
        .req      (stage_r),
        .idx      (pick_idx_s),
        .clr_mask (pick_clr_s)
    );

    // FSM state register.
    always_ff @(posedge trace_clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; arm low or a blocking event overrides the walk.
    always_comb begin
        state_next_s = state_r;
        if (!live_s) begin
            state_next_s = ST_IDLE;
        end else if (block_s) begin
            state_next_s = ST_BLOCKED;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (capture_s) begin
                        state_next_s = (|(delta_r & ~LOW_MASK)) ? ST_EMIT_TIME : ST_EMIT_MATCH;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_EMIT_TIME:  state_next_s = ST_EMIT_MATCH;
                ST_EMIT_MATCH: state_next_s = (|stage_after_s) ? ST_EMIT_MATCH : ST_IDLE;
                ST_BLOCKED:    state_next_s = ST_BLOCKED;
                default:       state_next_s = ST_IDLE;
            endcase
        end
    end

    // FSM output logic: the record to be written on the next edge.
    always_comb begin
        wr_s   = 1'b0;
        cmd_s  = FE_FIFO_CMD_NONE;
        rule_s = 8'd0;
        time_s = {pFULL_W{1'b0}};
        trig_s = 1'b0;
        if (write_s) begin
            wr_s = 1'b1;
            case (state_r)
                ST_EMIT_TIME: begin
                    cmd_s  = FE_FIFO_CMD_TIME;
                    time_s = sdelta_r & ~LOW_MASK;
                end
                ST_EMIT_MATCH: begin
                    cmd_s  = FE_FIFO_CMD_MATCH;
                    rule_s = pick_idx_s;
                    time_s = first_r ? (sdelta_r & LOW_MASK) : {pFULL_W{1'b0}};
                    trig_s = |(trig_enable & pick_clr_s);
                end
                default: begin
                    cmd_s = FE_FIFO_CMD_NONE;
                end
            endcase
        end else begin
            wr_s = 1'b0;
        end
    end

    // Staging update: load on capture, retire one rule per MATCH write, flush on abort/block.
    always_comb begin
        stage_next_s = stage_r;
        first_next_s = first_r;
        if (!live_s || block_s) begin
            stage_next_s = {pNUM_RULES{1'b0}};
            first_next_s = 1'b0;
        end else if (capture_s) begin
            stage_next_s = hits_s;
            first_next_s = 1'b1;
        end else if (write_s && (state_r == ST_EMIT_MATCH)) begin
            stage_next_s = stage_after_s;
            first_next_s = 1'b0;
        end else begin
            stage_next_s = stage_r;
            first_next_s = first_r;
        end
    end

    // Datapath registers: delta counter, captured delta, staging and sticky flags.
    always_ff @(posedge trace_clk or negedge resetn) begin
        if (!resetn) begin
            arm_q_r    <= 1'b0;
            delta_r    <= {pFULL_W{1'b0}};
            sdelta_r   <= {pFULL_W{1'b0}};
            stage_r    <= {pNUM_RULES{1'b0}};
            first_r    <= 1'b0;
            busy_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            arm_q_r <= arm;
            stage_r <= stage_next_s;
            first_r <= first_next_s;
            busy_r  <= |stage_next_s;
            if (!live_s) begin
                delta_r  <= {pFULL_W{1'b0}};
                sdelta_r <= {pFULL_W{1'b0}};
            end else if (capture_s) begin
                delta_r  <= DELTA_ONE;
                sdelta_r <= delta_r;
            end else if (delta_r != DELTA_MAX) begin
                delta_r  <= delta_r + DELTA_ONE;
            end
            if (arm_rise_s) begin
                overflow_r <= 1'b0;
            end else if (block_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Output registers: write strobe and trigger leave on the same edge.
    always_ff @(posedge trace_clk or negedge resetn) begin
        if (!resetn) begin
            fifo.fifo_wr   <= 1'b0;
            fifo.fifo_cmd  <= FE_FIFO_CMD_NONE;
            fifo.fifo_rule <= 8'd0;
            fifo.fifo_time <= {pFULL_W{1'b0}};
            trig_out       <= 1'b0;
        end else begin
            fifo.fifo_wr   <= wr_s;
            fifo.fifo_cmd  <= cmd_s;
            fifo.fifo_rule <= rule_s;
            fifo.fifo_time <= time_s;
            trig_out       <= trig_s;
        end
    end

    assign overflow_blocked = overflow_r;
    assign busy             = busy_r;

endmodule

// File: tb/tb_trace_event_scheduler.sv
// Directed bench for trace_event_scheduler: each task drives one scenario and
// compares the registered FIFO record against hand-computed values.
module tb_trace_event_scheduler;
    import trace_event_scheduler_pkg::*;

    logic       trace_clk;
    logic       resetn;
    logic       arm;
    logic [7:0] match_hit;
    logic [7:0] rule_enable;
    logic [7:0] trig_enable;
    logic       trig_out;
    logic       overflow_blocked;
    logic       busy;

    int n_cmp;
    int n_fail;
    logic [27:0] exp_rec;

    trace_event_scheduler_if #(.pFULL_W(16)) fifo_if ();

    trace_event_scheduler #(
        .pNUM_RULES (8),
        .pSHORT_W   (8),
        .pFULL_W    (16)
    ) dut (
        .trace_clk        (trace_clk),
        .resetn           (resetn),
        .arm              (arm),
        .match_hit        (match_hit),
        .rule_enable      (rule_enable),
        .trig_enable      (trig_enable),
        .fifo             (fifo_if),
        .trig_out         (trig_out),
        .overflow_blocked (overflow_blocked),
        .busy             (busy)
    );

    initial trace_clk = 1'b0;
    always #5 trace_clk = ~trace_clk;

    // Observed record: {wr, cmd, rule, time, trig}.
    function automatic logic [27:0] obs();
        return {fifo_if.fifo_wr, fifo_if.fifo_cmd, fifo_if.fifo_rule, fifo_if.fifo_time, trig_out};
    endfunction

    task automatic step();
        @(posedge trace_clk);
        #1;
    endtask

    // Restart capture, idle d cycles after the arm edge, then present hits for one
    // cycle; the hit is captured with delta = d.
    task automatic hit_at(input int d, input logic [7:0] h);
        arm = 1'b0;
        step();
        arm = 1'b1;
        step();
        repeat (d) step();
        match_hit = h;
        step();
        match_hit = 8'h00;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== 28'd0 || busy !== 1'b0 || overflow_blocked !== 1'b0) begin
            $display("FAIL reset_async: rec=%h busy=%b ovf=%b, expected all 0", obs(), busy, overflow_blocked);
            n_fail++;
        end
        step();
        step();
        n_cmp++;
        if (obs() !== 28'd0 || busy !== 1'b0 || overflow_blocked !== 1'b0) begin
            $display("FAIL reset_hold: rec=%h busy=%b ovf=%b, expected all 0", obs(), busy, overflow_blocked);
            n_fail++;
        end
        resetn = 1'b1;
        step();
    endtask

    task automatic test_single_match();
        rule_enable = 8'hDF;
        hit_at(10, 8'h24);
        n_cmp++;
        if (fifo_if.fifo_wr !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL single_latency: wr=%b busy=%b, expected wr=0 busy=1", fifo_if.fifo_wr, busy);
            n_fail++;
        end
        step();
        exp_rec = {1'b1, FE_FIFO_CMD_MATCH, 8'd2, 16'd10, 1'b0};
        n_cmp++;
        if (obs() !== exp_rec) begin
            $display("FAIL single_rec: got %h expected %h", obs(), exp_rec);
            n_fail++;
        end
        step();
        n_cmp++;
        if (fifo_if.fifo_wr !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL single_done: wr=%b busy=%b, expected 0 0", fifo_if.fifo_wr, busy);
            n_fail++;
        end
        rule_enable = 8'hFF;
    endtask

    task automatic test_multi_match();
        logic [7:0] rules [3] = '{8'd1, 8'd3, 8'd6};
        logic [15:0] times [3] = '{16'd5, 16'd0, 16'd0};
        logic        busys [3] = '{1'b1, 1'b1, 1'b0};
        hit_at(5, 8'h4A);
        n_cmp++;
        if (busy !== 1'b1) begin
            $display("FAIL multi_busy_start: busy=%b expected 1", busy);
            n_fail++;
        end
        for (int i = 0; i < 3; i++) begin
            step();
            exp_rec = {1'b1, FE_FIFO_CMD_MATCH, rules[i], times[i], 1'b0};
            n_cmp++;
            if (obs() !== exp_rec || busy !== busys[i]) begin
                $display("FAIL multi_rec%0d: got %h busy=%b expected %h busy=%b", i, obs(), busy, exp_rec, busys[i]);
                n_fail++;
            end
        end
        step();
        n_cmp++;
        if (fifo_if.fifo_wr !== 1'b0) begin
            $display("FAIL multi_tail: wr=%b expected 0", fifo_if.fifo_wr);
            n_fail++;
        end
    endtask

    task automatic test_time_gap();
        logic [15:0] sum;
        trig_enable = 8'h01;
        hit_at(700, 8'h01);
        step();
        exp_rec = {1'b1, FE_FIFO_CMD_TIME, 8'd0, 16'd512, 1'b0};
        n_cmp++;
        if (obs() !== exp_rec) begin
            $display("FAIL gap_time_rec: got %h expected %h", obs(), exp_rec);
            n_fail++;
        end
        sum = fifo_if.fifo_time;
        step();
        exp_rec = {1'b1, FE_FIFO_CMD_MATCH, 8'd0, 16'd188, 1'b1};
        n_cmp++;
        if (obs() !== exp_rec) begin
            $display("FAIL gap_match_rec: got %h expected %h", obs(), exp_rec);
            n_fail++;
        end
        sum = sum + fifo_if.fifo_time;
        n_cmp++;
        if (sum !== 16'd700) begin
            $display("FAIL gap_reader_sum: got %0d expected 700", sum);
            n_fail++;
        end
        trig_enable = 8'h00;
    endtask

    task automatic test_trigger();
        trig_enable = 8'h02;
        hit_at(3, 8'h03);
        step();
        exp_rec = {1'b1, FE_FIFO_CMD_MATCH, 8'd0, 16'd3, 1'b0};
        n_cmp++;
        if (obs() !== exp_rec) begin
            $display("FAIL trig_rec0: got %h expected %h", obs(), exp_rec);
            n_fail++;
        end
        step();
        exp_rec = {1'b1, FE_FIFO_CMD_MATCH, 8'd1, 16'd0, 1'b1};
        n_cmp++;
        if (obs() !== exp_rec) begin
            $display("FAIL trig_rec1: got %h expected %h", obs(), exp_rec);
            n_fail++;
        end
        step();
        n_cmp++;
        if (trig_out !== 1'b0 || fifo_if.fifo_wr !== 1'b0) begin
            $display("FAIL trig_tail: trig=%b wr=%b expected 0 0", trig_out, fifo_if.fifo_wr);
            n_fail++;
        end
        trig_enable = 8'h00;
    endtask

    task automatic test_back_to_back();
        hit_at(2, 8'h01);
        match_hit = 8'h02;
        step();
        match_hit = 8'h00;
        exp_rec = {1'b1, FE_FIFO_CMD_MATCH, 8'd0, 16'd2, 1'b0};
        n_cmp++;
        if (obs() !== exp_rec || overflow_blocked !== 1'b1) begin
            $display("FAIL b2b_last_bit: got %h ovf=%b expected %h ovf=1", obs(), overflow_blocked, exp_rec);
            n_fail++;
        end
        step();
        n_cmp++;
        if (fifo_if.fifo_wr !== 1'b0) begin
            $display("FAIL b2b_dropped: wr=%b expected 0", fifo_if.fifo_wr);
            n_fail++;
        end
    endtask

    task automatic test_overflow();
        int writes;
        hit_at(2, 8'h06);
        match_hit = 8'h10;
        step();
        match_hit = 8'h00;
        exp_rec = {1'b1, FE_FIFO_CMD_MATCH, 8'd1, 16'd2, 1'b0};
        n_cmp++;
        if (obs() !== exp_rec || overflow_blocked !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL ovf_busy_hit: got %h ovf=%b busy=%b expected %h ovf=1 busy=0",
                     obs(), overflow_blocked, busy, exp_rec);
            n_fail++;
        end
        writes = 0;
        match_hit = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            step();
            writes += int'(fifo_if.fifo_wr);
        end
        match_hit = 8'h00;
        n_cmp++;
        if (writes != 0) begin
            $display("FAIL ovf_no_writes: got %0d writes expected 0", writes);
            n_fail++;
        end
        arm = 1'b0;
        step();
        n_cmp++;
        if (overflow_blocked !== 1'b1) begin
            $display("FAIL ovf_sticky_arm_low: ovf=%b expected 1", overflow_blocked);
            n_fail++;
        end
        arm = 1'b1;
        step();
        n_cmp++;
        if (overflow_blocked !== 1'b0) begin
            $display("FAIL ovf_clear_rearm: ovf=%b expected 0", overflow_blocked);
            n_fail++;
        end
        // fifo_full with no hit pending is harmless; then full on a write blocks.
        fifo_if.fifo_full = 1'b1;
        repeat (4) step();
        fifo_if.fifo_full = 1'b0;
        n_cmp++;
        if (overflow_blocked !== 1'b0) begin
            $display("FAIL ovf_full_idle: ovf=%b expected 0", overflow_blocked);
            n_fail++;
        end
        match_hit = 8'h20;
        step();
        match_hit = 8'h00;
        fifo_if.fifo_full = 1'b1;
        step();
        fifo_if.fifo_full = 1'b0;
        n_cmp++;
        if (fifo_if.fifo_wr !== 1'b0 || overflow_blocked !== 1'b1) begin
            $display("FAIL ovf_full_write: wr=%b ovf=%b expected 0 1", fifo_if.fifo_wr, overflow_blocked);
            n_fail++;
        end
        step();
        n_cmp++;
        if (fifo_if.fifo_wr !== 1'b0) begin
            $display("FAIL ovf_full_after: wr=%b expected 0", fifo_if.fifo_wr);
            n_fail++;
        end
        // Re-arm restarts delta from zero.
        hit_at(4, 8'h80);
        step();
        exp_rec = {1'b1, FE_FIFO_CMD_MATCH, 8'd7, 16'd4, 1'b0};
        n_cmp++;
        if (obs() !== exp_rec || overflow_blocked !== 1'b0) begin
            $display("FAIL ovf_restart: got %h ovf=%b expected %h ovf=0", obs(), overflow_blocked, exp_rec);
            n_fail++;
        end
    endtask

    task automatic test_arm_abort();
        hit_at(2, 8'h0F);
        step();
        exp_rec = {1'b1, FE_FIFO_CMD_MATCH, 8'd0, 16'd2, 1'b0};
        n_cmp++;
        if (obs() !== exp_rec) begin
            $display("FAIL abort_first: got %h expected %h", obs(), exp_rec);
            n_fail++;
        end
        arm = 1'b0;
        step();
        n_cmp++;
        if (obs() !== 28'd0 || busy !== 1'b0) begin
            $display("FAIL abort_stop: got %h busy=%b expected 0 busy=0", obs(), busy);
            n_fail++;
        end
        arm = 1'b1;
        step();
        step();
        n_cmp++;
        if (fifo_if.fifo_wr !== 1'b0) begin
            $display("FAIL abort_no_resume: wr=%b expected 0", fifo_if.fifo_wr);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        int writes;
        hit_at(2, 8'h07);
        step();
        #2;
        resetn = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== 28'd0 || busy !== 1'b0 || overflow_blocked !== 1'b0) begin
            $display("FAIL rst_mid_outputs: rec=%h busy=%b ovf=%b expected all 0", obs(), busy, overflow_blocked);
            n_fail++;
        end
        step();
        step();
        resetn = 1'b1;
        writes = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            writes += int'(fifo_if.fifo_wr);
        end
        n_cmp++;
        if (writes != 0) begin
            $display("FAIL rst_mid_residual: got %0d writes expected 0", writes);
            n_fail++;
        end
    endtask

    initial begin
        n_cmp             = 0;
        n_fail            = 0;
        resetn            = 1'b0;
        arm               = 1'b0;
        match_hit         = 8'h00;
        rule_enable       = 8'hFF;
        trig_enable       = 8'h00;
        fifo_if.fifo_full = 1'b0;
        test_reset();
        test_single_match();
        test_multi_match();
        test_time_gap();
        test_trigger();
        test_back_to_back();
        test_overflow();
        test_arm_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
